count_sequencer: RTL and testbench

Controller that sequences a WIDTH-bit binary counter through runs. A run starts on request and goes up or down between a start value and a programmable terminal value. Each run is either continuous (wrap and repeat) or one-shot (stop and flag done). It wraps the team's D-flip-flop counter datapath with start/pause/restart control and status outputs for higher-level FSMs.

---
 rtl/count_sequencer.sv | 123 ++++++++++++
 tb/tb_count_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
`timescale 1ns/1ps
// count_sequencer
// Sequences a WIDTH-bit binary counter through up/down runs between a start
// value and a programmable terminal value, in continuous (wrap) or one-shot
// (stop and flag done) mode, with pause and restart control.
//
// Ports:
//   clock    - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   start    - begin a run; restarts while in RUN or PAUSE
//   pause    - level; holds the count while high during a run
//   dir      - 0 = up, 1 = down (sampled on start)
//   oneshot  - 0 = continuous, 1 = stop at terminal (sampled on start)
//   limit    - up: terminal value, down: start value (sampled on start)
//   count    - current counter value
//   busy     - high in RUN or PAUSE
//   done     - one-cycle pulse on one-shot completion
//   wrap     - one-cycle pulse on continuous-mode reload
//   state    - FSM state: IDLE=00 RUN=01 PAUSE=10 DONE=11
module count_sequencer #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             pause,
   input  logic             dir,
   input  logic             oneshot,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t           state_q;
   logic             dir_q;
   logic             oneshot_q;
   logic [WIDTH-1:0] limit_q;

   // Load value for a (re)start uses the live inputs being latched this edge.
   logic [WIDTH-1:0] load_val;
   // Start and terminal values of the run in progress use the latched inputs.
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] term_val;

   assign load_val  = dir   ? limit   : '0;
   assign start_val = dir_q ? limit_q : '0;
   assign term_val  = dir_q ? '0      : limit_q;

   assign state = state_q;

   // Sequencer FSM with registered count and status outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wrap      <= 1'b0;
         dir_q     <= 1'b0;
         oneshot_q <= 1'b0;
         limit_q   <= '0;
      end else begin
         // Pulses default low; set only on the edge that causes them.
         wrap <= 1'b0;
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  dir_q     <= dir;
                  oneshot_q <= oneshot;
                  limit_q   <= limit;
                  count     <= load_val;
                  state_q   <= RUN;
                  busy      <= 1'b1;
               end
            end
            RUN, PAUSE: begin
               if (start) begin
                  dir_q     <= dir;
                  oneshot_q <= oneshot;
                  limit_q   <= limit;
                  count     <= load_val;
                  state_q   <= RUN;
                  busy      <= 1'b1;
               end else if (pause) begin
                  state_q <= PAUSE;
               end else if (state_q == PAUSE) begin
                  // Resume edge only changes state; stepping restarts next edge.
                  state_q <= RUN;
               end else if (count != term_val) begin
                  count <= dir_q ? (count - WIDTH'(1)) : (count + WIDTH'(1));
               end else if (!oneshot_q) begin
                  count <= start_val;
                  wrap  <= 1'b1;
               end else begin
                  state_q <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            DONE: begin
               // Single-cycle state; start is ignored here.
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_count_sequencer.sv
`timescale 1ns/1ps
// tb_count_sequencer
// Directed testbench for count_sequencer (WIDTH=2) with hand-computed
// expected sequences, one task per scenario.
module tb_count_sequencer;

   localparam int unsigned WIDTH = 2;

   logic             clock;
   logic             reset_n;
   logic             start;
   logic             pause;
   logic             dir;
   logic             oneshot;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             wrap;
   logic [1:0]       state;

   int n_tests = 0;
   int n_fail  = 0;

   count_sequencer #(.WIDTH(WIDTH)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .pause   (pause),
      .dir     (dir),
      .oneshot (oneshot),
      .limit   (limit),
      .count   (count),
      .busy    (busy),
      .done    (done),
      .wrap    (wrap),
      .state   (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Short reset pulse placed between clock edges.
   task automatic do_reset();
      start   = 1'b0;
      pause   = 1'b0;
      dir     = 1'b0;
      oneshot = 1'b0;
      limit   = '0;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if (count !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0 || state !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_values got count=%0d busy=%b done=%b wrap=%b state=%b exp 0 0 0 0 00",
                  count, busy, done, wrap, state);
      end
      #11;
      reset_n = 1'b1;
      tick();
      tick();
      n_tests++;
      if (count !== 2'd0 || busy !== 1'b0 || state !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_idle_hold got count=%0d busy=%b state=%b exp 0 0 00", count, busy, state);
      end
   endtask

   task automatic test_up_wrap();
      int exp_c[7] = '{0, 1, 2, 3, 0, 1, 2};
      int exp_w[7] = '{0, 0, 0, 0, 1, 0, 0};
      do_reset();
      dir = 1'b0; oneshot = 1'b0; limit = 2'd3; start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         start = 1'b0;
         // Mid-run input changes must not affect the latched run.
         dir = 1'b1; limit = 2'd1; oneshot = 1'b1;
         n_tests++;
         if (count !== exp_c[i] || wrap !== exp_w[i][0] || busy !== 1'b1 || state !== 2'b01 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL up_wrap[%0d] got count=%0d wrap=%b busy=%b state=%b done=%b exp count=%0d wrap=%0d busy=1 state=01 done=0",
                     i, count, wrap, busy, state, done, exp_c[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_down_oneshot();
      int exp_c[6] = '{2, 1, 0, 0, 0, 0};
      int exp_s[6] = '{1, 1, 1, 3, 0, 0};
      int exp_d[6] = '{0, 0, 0, 1, 0, 0};
      int exp_b[6] = '{1, 1, 1, 0, 0, 0};
      do_reset();
      dir = 1'b1; oneshot = 1'b1; limit = 2'd2; start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         // start while in DONE (index 3) must be ignored.
         start = (i == 3);
         if (i == 3) begin
            dir = 1'b0; limit = 2'd3;
         end
         n_tests++;
         if (count !== exp_c[i] || state !== exp_s[i][1:0] || done !== exp_d[i][0] || busy !== exp_b[i][0] || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL down_oneshot[%0d] got count=%0d state=%0d done=%b busy=%b wrap=%b exp count=%0d state=%0d done=%0d busy=%0d wrap=0",
                     i, count, state, done, busy, wrap, exp_c[i], exp_s[i], exp_d[i], exp_b[i]);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_pause();
      int exp_c[9] = '{0, 1, 2, 2, 2, 2, 2, 3, 0};
      int exp_s[9] = '{1, 1, 1, 2, 2, 2, 1, 1, 1};
      int exp_w[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
      do_reset();
      dir = 1'b0; oneshot = 1'b0; limit = 2'd3; start = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         start = 1'b0;
         pause = (i >= 2 && i <= 4);
         n_tests++;
         if (count !== exp_c[i] || state !== exp_s[i][1:0] || wrap !== exp_w[i][0] || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pause[%0d] got count=%0d state=%0d wrap=%b busy=%b exp count=%0d state=%0d wrap=%0d busy=1",
                     i, count, state, wrap, busy, exp_c[i], exp_s[i], exp_w[i]);
         end
      end
      pause = 1'b0;
   endtask

   task automatic test_restart();
      int exp_c[7] = '{0, 1, 2, 1, 0, 1, 0};
      int exp_w[7] = '{0, 0, 0, 0, 0, 1, 0};
      do_reset();
      dir = 1'b0; oneshot = 1'b0; limit = 2'd3; start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         start = 1'b0;
         if (i == 2) begin
            start = 1'b1; dir = 1'b1; limit = 2'd1;
         end else if (i == 3) begin
            dir = 1'b0; limit = 2'd3;
         end
         n_tests++;
         if (count !== exp_c[i] || wrap !== exp_w[i][0] || state !== 2'b01) begin
            n_fail++;
            $display("FAIL restart[%0d] got count=%0d wrap=%b state=%b exp count=%0d wrap=%0d state=01",
                     i, count, wrap, state, exp_c[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      dir = 1'b0; oneshot = 1'b0; limit = 2'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      n_tests++;
      if (count !== 2'd2 || state !== 2'b01) begin
         n_fail++;
         $display("FAIL async_pre got count=%0d state=%b exp count=2 state=01", count, state);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (count !== 2'd0 || busy !== 1'b0 || state !== 2'b00 || wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got count=%0d busy=%b state=%b wrap=%b exp 0 0 00 0", count, busy, state, wrap);
      end
      #2;
      reset_n = 1'b1;
      tick();
      tick();
      n_tests++;
      if (count !== 2'd0 || busy !== 1'b0 || state !== 2'b00) begin
         n_fail++;
         $display("FAIL async_release got count=%0d busy=%b state=%b exp 0 0 00", count, busy, state);
      end
   endtask

   task automatic test_degenerate();
      do_reset();
      dir = 1'b0; oneshot = 1'b0; limit = 2'd0; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         start = 1'b0;
         n_tests++;
         if (count !== 2'd0 || wrap !== (i != 0) || state !== 2'b01) begin
            n_fail++;
            $display("FAIL degen_cont[%0d] got count=%0d wrap=%b state=%b exp count=0 wrap=%0d state=01",
                     i, count, wrap, state, (i != 0));
         end
      end
      do_reset();
      dir = 1'b0; oneshot = 1'b1; limit = 2'd0; start = 1'b1;
      tick();
      start = 1'b0;
      n_tests++;
      if (state !== 2'b01 || done !== 1'b0 || count !== 2'd0) begin
         n_fail++;
         $display("FAIL degen_os_run got state=%b done=%b count=%0d exp 01 0 0", state, done, count);
      end
      tick();
      n_tests++;
      if (state !== 2'b11 || done !== 1'b1 || busy !== 1'b0 || wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL degen_os_done got state=%b done=%b busy=%b wrap=%b exp 11 1 0 0", state, done, busy, wrap);
      end
      tick();
      n_tests++;
      if (state !== 2'b00 || done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL degen_os_idle got state=%b done=%b busy=%b exp 00 0 0", state, done, busy);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      pause   = 1'b0;
      dir     = 1'b0;
      oneshot = 1'b0;
      limit   = '0;
      test_reset();
      test_up_wrap();
      test_down_oneshot();
      test_pause();
      test_restart();
      test_async_reset();
      test_degenerate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
